// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, FSM states, counter sizing.
// No logic; imported by the sequencer and its compute datapath.
// Not applicable: holds no flow control.
package md_sequencer_pkg;

  // Op encoding as issued by the E stage; bit 0 set means the unsigned variant.
  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MADD  = 3'b100,
    MD_MADDU = 3'b101,
    MD_MSUB  = 3'b110,
    MD_MSUBU = 3'b111
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int CNT_W      = 4;
  localparam int CNT_LIMIT  = 15;

  // Divide ops are the only ones routed to the long latency.
  function automatic logic is_div(input logic [2:0] op);
    return (op[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/md_sequencer_compute.sv
// Combinational mul/div/accumulate datapath producing the 64-bit {HI,LO} result of one MD op.
// Zero latency: result is valid in the same cycle as the operands.
// No backpressure; commit_o drops for divide-by-zero so the caller leaves HI/LO untouched.
module md_sequencer_compute
  import md_sequencer_pkg::*;
(
  input  logic [2:0]  md_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [63:0] res_o,
  output logic        commit_o
);

  logic        op_signed;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [63:0] acc;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign op_signed = ~md_op_i[0];

  // Low 64 bits of a product of sign/zero-extended operands are the exact 32x32 result.
  assign ext_a = op_signed ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
  assign ext_b = op_signed ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
  assign prod  = ext_a * ext_b;
  assign acc   = {hi_i, lo_i};

  // Sign-magnitude division keeps INT_MIN/-1 well defined and gives truncation toward zero.
  assign a_neg = op_signed & a_i[31];
  assign b_neg = op_signed & b_i[31];
  assign a_mag = a_neg ? (32'd0 - a_i) : a_i;
  assign b_mag = (b_i == 32'd0) ? 32'd1 : (b_neg ? (32'd0 - b_i) : b_i);
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

  // Select the result for the requested op; only a zero divisor suppresses the commit.
  always_comb begin
    res_o    = prod;
    commit_o = 1'b1;
    case (md_op_e'(md_op_i))
      MD_MULT, MD_MULTU: res_o = prod;
      MD_DIV, MD_DIVU: begin
        res_o    = {rem, quot};
        commit_o = (b_i != 32'd0);
      end
      MD_MADD, MD_MADDU: res_o = acc + prod;
      MD_MSUB, MD_MSUBU: res_o = acc - prod;
      default:           res_o = prod;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Owns HI/LO, issues one MD op per start and holds Busy for the op's fixed latency before committing.
// Latency: Busy high MULT_CYCLES/DIV_CYCLES cycles from the cycle after start; HI/LO update on the last edge.
// Backpressure: stall_md_o asks the hazard unit to hold D while an MD-class instr meets a live op.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [2:0]  md_op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        hi_write_i,
  input  logic        lo_write_i,
  input  logic        d_md_i,
  output logic        busy_o,
  output logic        stall_md_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] lat_d;
  logic [31:0]      hs_q;
  logic [31:0]      ls_q;
  logic             commit_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [63:0]      res;
  logic             res_commit;

  // Accumulate ops read the architectural HI/LO as they stand in the start cycle.
  md_sequencer_compute u_compute (
    .md_op_i  (md_op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .res_o    (res),
    .commit_o (res_commit)
  );

  assign lat_d = is_div(md_op_i) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  assign cnt_d = cnt_q - CNT_W'(1);

  // Issue/countdown FSM; shadow result is parked until the final RUN edge so HI/LO never show partials.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hs_q     <= '0;
      ls_q     <= '0;
      commit_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            // A move-to-HI/LO in the same cycle as start is dropped.
            hs_q     <= res[63:32];
            ls_q     <= res[31:0];
            commit_q <= res_commit;
            cnt_q    <= lat_d;
            state_q  <= ST_RUN;
          end else begin
            if (hi_write_i) hi_q <= a_i;
            if (lo_write_i) lo_q <= a_i;
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_d;
          if (cnt_q == CNT_W'(1)) begin
            if (commit_q) begin
              hi_q <= hs_q;
              lo_q <= ls_q;
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o     = (state_q == ST_RUN);
  assign stall_md_o = d_md_i & (start_i | busy_o);
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        hi_wr;
  logic        lo_wr;
  logic        d_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;
  logic [63:0] exp_q[$];

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .md_op_i    (md_op),
    .a_i        (a_in),
    .b_i        (b_in),
    .hi_write_i (hi_wr),
    .lo_write_i (lo_wr),
    .d_md_i     (d_md),
    .busy_o     (busy),
    .stall_md_o (stall),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic mt_write(input logic [31:0] a, input logic wh, input logic wl,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    a_in = a; hi_wr = wh; lo_wr = wl;
    @(negedge clk);
    hi_wr = 1'b0; lo_wr = 1'b0;
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
  endtask

  // Issue one op, measure Busy length, check stall/hold, then pop the expected {HI,LO}.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int n, input logic dmd, input logic wr_with_start,
                       input logic disturb, input string tag);
    logic [63:0] pre;
    logic [63:0] exp;
    int cyc;
    pre = {hi, lo};
    md_op = op; a_in = a; b_in = b; d_md = dmd; start = 1'b1;
    hi_wr = wr_with_start; lo_wr = wr_with_start;
    #1;
    chk({tag, "_stall_start"}, {63'd0, stall}, {63'd0, dmd});
    @(negedge clk);
    start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      chk({tag, "_stall_busy"}, {63'd0, stall}, {63'd0, dmd});
      chk({tag, "_hold"}, {hi, lo}, pre);
      if (disturb && cyc == 2) begin
        start = 1'b1; md_op = MD_MULT; a_in = 32'd0; b_in = 32'd0;
        hi_wr = 1'b1; lo_wr = 1'b1;
      end
      @(negedge clk);
      start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    end
    chk({tag, "_busy_cycles"}, 64'(cyc), 64'(n));
    chk({tag, "_stall_after"}, {63'd0, stall}, 64'd0);
    d_md = 1'b0;
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
    end else begin
      exp = exp_q.pop_front();
      chk({tag, "_result"}, {hi, lo}, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; md_op = 3'd0; a_in = '0; b_in = '0;
    hi_wr = 1'b0; lo_wr = 1'b0; d_md = 1'b1;
    #3;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_stall", {63'd0, stall}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    d_md = 1'b0;
    @(negedge clk);

    // Signed multiply; same-cycle mthi/mtlo must be dropped; D-stage MD instr stalls throughout.
    exp_q.push_back(64'hFFFFFFFF_FFFFFFF1);
    do_op(MD_MULT, 32'hFFFFFFFD, 32'd5, 5, 1'b1, 1'b1, 1'b0, "mult");

    // Unsigned divide with start and writes poked mid-flight (must be ignored).
    exp_q.push_back({32'd2, 32'd3});
    do_op(MD_DIVU, 32'd17, 32'd5, 10, 1'b0, 1'b0, 1'b1, "divu");
    exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
    do_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 1'b0, 1'b0, 1'b0, "div_neg_dividend");
    exp_q.push_back({32'd1, 32'hFFFFFFFD});
    do_op(MD_DIV, 32'd7, 32'hFFFFFFFE, 10, 1'b0, 1'b0, 1'b0, "div_neg_divisor");

    // Both moves in one cycle, then separate mtlo / mthi.
    mt_write(32'h55, 1'b1, 1'b1, 32'h55, 32'h55, "mt_both");
    mt_write(32'h1, 1'b0, 1'b1, 32'h55, 32'h1, "mtlo");
    mt_write(32'h0, 1'b1, 1'b0, 32'h0, 32'h1, "mthi");

    // Accumulate family, each building on the previous {HI,LO}.
    exp_q.push_back(64'h00000001_FFFFFFFF);
    do_op(MD_MADDU, 32'hFFFFFFFF, 32'd2, 5, 1'b0, 1'b0, 1'b0, "maddu");
    exp_q.push_back(64'h00000001_FFFFFFF3);
    do_op(MD_MSUB, 32'd3, 32'd4, 5, 1'b0, 1'b0, 1'b0, "msub");
    exp_q.push_back(64'h00000001_FFFFFFF4);
    do_op(MD_MADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b0, 1'b0, 1'b0, "madd");
    exp_q.push_back(64'hFFFFFFFE_00000001);
    do_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b0, 1'b0, 1'b0, "multu");
    exp_q.push_back(64'hFFFFFFFD_FFFFFFFB);
    do_op(MD_MSUBU, 32'd2, 32'd3, 5, 1'b0, 1'b0, 1'b0, "msubu");

    // Divide by zero: full latency, no commit.
    mt_write(32'h12, 1'b1, 1'b0, 32'h12, 32'hFFFFFFFB, "mthi12");
    mt_write(32'h34, 1'b0, 1'b1, 32'h12, 32'h34, "mtlo34");
    exp_q.push_back({32'h12, 32'h34});
    do_op(MD_DIV, 32'd100, 32'd0, 10, 1'b1, 1'b0, 1'b0, "div_by_zero");

    // Reset on the third Busy cycle aborts the op with no partial commit.
    md_op = MD_MULT; a_in = 32'd7; b_in = 32'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("abort_busy_c1", {63'd0, busy}, 64'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("abort_no_commit", {hi, lo}, 64'd0);
    chk("abort_idle", {63'd0, busy}, 64'd0);
    exp_q.push_back({32'd0, 32'd6});
    do_op(MD_MULT, 32'd2, 32'd3, 5, 1'b0, 1'b0, 1'b0, "mult_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
